// File: rtl/uart_pkg.sv
// Shared definitions for the serial hex loader: ASCII codes, receiver state
// encoding and small character helpers.
package uart_pkg;

    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_DOT = 8'h2E;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Letters land on 0x_1..0x_6 in both cases, so +9 gives 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

endpackage

// File: rtl/uart_hex_loader_if.sv
// Bundle between the serial/display world and the hex loader core.
interface uart_hex_loader_if import uart_pkg::*; ();

    logic        usb_rx;
    logic        err_clr;
    logic [15:0] disp_value;
    logic [3:0]  disp_dots;
    logic        disp_update;
    logic        err_frame;
    logic        err_char;
    rx_state_e   dbg_rx_state;

    // disp_update is a one-cycle valid with no ready: the display always
    // accepts, and disp_value/disp_dots hold steady until the next pulse.
    modport master (
        output usb_rx, err_clr,
        input  disp_value, disp_dots, disp_update, err_frame, err_char, dbg_rx_state
    );

    modport slave (
        input  usb_rx, err_clr,
        output disp_value, disp_dots, disp_update, err_frame, err_char, dbg_rx_state
    );

endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: two-flop synchronizer plus a mid-bit sampling FSM.
// Emits one-cycle rx_valid_o / frame_err_o pulses.
module uart_rx_8n1 import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output rx_state_e  state_o
);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_rx_8n1: CLKS_PER_BIT must be at least 4");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q;
    logic             frame_err_q;

    // Idle-high reset value keeps a quiet line from looking like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx_sync_q) state_q <= RX_START;
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            rx_byte_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= RX_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_sync_q) state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte_o   = rx_byte_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign state_o     = state_q;

endmodule

// File: rtl/uart_hex_loader.sv
// Parses received ASCII hex digits and dots into a 4-digit staged value and
// commits it to the display registers on CR/LF.
module uart_hex_loader import uart_pkg::*; #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_hex_loader_if.slave   bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    rx_state_e  rx_state;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (bus.usb_rx),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err),
        .state_o    (rx_state)
    );

    logic [15:0] stage_q,     stage_d;
    logic [3:0]  dstage_q,    dstage_d;
    logic [2:0]  nib_cnt_q,   nib_cnt_d;
    logic [15:0] value_q,     value_d;
    logic [3:0]  dots_q,      dots_d;
    logic        update_q,    update_d;
    logic        err_frame_q, err_frame_d;
    logic        err_char_q,  err_char_d;

    always_comb begin
        stage_d     = stage_q;
        dstage_d    = dstage_q;
        nib_cnt_d   = nib_cnt_q;
        value_d     = value_q;
        dots_d      = dots_q;
        update_d    = 1'b0;
        // A new error in the same cycle as err_clr keeps the flag set.
        err_frame_d = frame_err | (err_frame_q & ~bus.err_clr);
        err_char_d  = err_char_q & ~bus.err_clr;
        if (rx_valid) begin
            if (is_hex(rx_byte)) begin
                stage_d   = {stage_q[11:0], hex_val(rx_byte)};
                dstage_d  = {dstage_q[2:0], 1'b0};
                nib_cnt_d = (nib_cnt_q == 3'd4) ? 3'd4 : (nib_cnt_q + 3'd1);
            end else if (rx_byte == CHR_DOT) begin
                dstage_d = dstage_q | 4'b0001;
            end else if ((rx_byte == CHR_CR) || (rx_byte == CHR_LF)) begin
                if (nib_cnt_q != 3'd0) begin
                    value_d  = stage_q;
                    dots_d   = dstage_q;
                    update_d = 1'b1;
                end
                stage_d   = '0;
                dstage_d  = '0;
                nib_cnt_d = '0;
            end else begin
                err_char_d = 1'b1;
                stage_d    = '0;
                dstage_d   = '0;
                nib_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q     <= '0;
            dstage_q    <= '0;
            nib_cnt_q   <= '0;
            value_q     <= '0;
            dots_q      <= '0;
            update_q    <= 1'b0;
            err_frame_q <= 1'b0;
            err_char_q  <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            dstage_q    <= dstage_d;
            nib_cnt_q   <= nib_cnt_d;
            value_q     <= value_d;
            dots_q      <= dots_d;
            update_q    <= update_d;
            err_frame_q <= err_frame_d;
            err_char_q  <= err_char_d;
        end
    end

    assign bus.disp_value   = value_q;
    assign bus.disp_dots    = dots_q;
    assign bus.disp_update  = update_q;
    assign bus.err_frame    = err_frame_q;
    assign bus.err_char     = err_char_q;
    assign bus.dbg_rx_state = rx_state;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Bench for uart_hex_loader: table-driven ASCII lines, hand-written corner
// sequences, then random characters scored against a digit-list model.
module tb_uart_hex_loader;
  import uart_pkg::*;

  localparam int CPB = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_hex_loader_if bus();

  uart_hex_loader #(
    .CLK_HZ(100_000_000),
    .BAUD  (1_000_000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- update monitor ----------------
  int upd_cnt = 0;
  logic [19:0] act_q[$];
  logic [19:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.disp_update) begin
      upd_cnt++;
      act_q.push_back({bus.disp_value, bus.disp_dots});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) bus.usb_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.usb_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.usb_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.usb_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk) bus.err_clr = 1'b1;
    @(negedge clk) bus.err_clr = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [47:0] text;
    int          len;
    logic [7:0]  term;
    logic [15:0] exp_val;
    logic [3:0]  exp_dots;
    int          exp_upd;
    logic        exp_ferr;
    logic        exp_cerr;
  } vec_t;

  vec_t vecs[8];

  task automatic set_vec(input int i, input string s, input logic [7:0] term,
                         input logic [15:0] v, input logic [3:0] d, input int u,
                         input logic fe, input logic ce);
    vecs[i].text = '0;
    for (int k = 0; k < s.len(); k++) vecs[i].text = {vecs[i].text[39:0], s[k]};
    vecs[i].len      = s.len();
    vecs[i].term     = term;
    vecs[i].exp_val  = v;
    vecs[i].exp_dots = d;
    vecs[i].exp_upd  = u;
    vecs[i].exp_ferr = fe;
    vecs[i].exp_cerr = ce;
  endtask

  task automatic apply_vec(input int i);
    int base;
    base = upd_cnt;
    for (int k = 0; k < vecs[i].len; k++)
      send_frame(vecs[i].text[8*(vecs[i].len-1-k) +: 8], 1'b1);
    send_frame(vecs[i].term, 1'b1);
    repeat (5) @(negedge clk);
    check($sformatf("v%0d_updates", i), upd_cnt - base, vecs[i].exp_upd);
    check($sformatf("v%0d_value", i), bus.disp_value, vecs[i].exp_val);
    check($sformatf("v%0d_dots", i), bus.disp_dots, vecs[i].exp_dots);
    check($sformatf("v%0d_err_frame", i), bus.err_frame, vecs[i].exp_ferr);
    check($sformatf("v%0d_err_char", i), bus.err_char, vecs[i].exp_cerr);
  endtask

  // ---------------- reference model ----------------
  // A line is a list of typed digits; a dot marks the latest digit, or an
  // implicit zero digit if none has been typed yet.
  logic [3:0] m_nib[$];
  bit         m_dot[$];
  int         m_real;
  logic       m_cerr;

  function automatic int tb_hex(input logic [7:0] c);
    string h;
    logic [7:0] lc;
    h  = "0123456789abcdef";
    lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    for (int i = 0; i < 16; i++) if (h[i] == lc) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_nib.delete();
    m_dot.delete();
    m_real = 0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    logic [15:0] v;
    logic [3:0]  d;
    int n;
    n = tb_hex(c);
    if (n >= 0) begin
      m_nib.push_back(4'(n));
      m_dot.push_back(1'b0);
      m_real++;
    end else if (c == ".") begin
      if (m_nib.size() == 0) begin
        m_nib.push_back(4'h0);
        m_dot.push_back(1'b0);
      end
      m_dot[m_dot.size()-1] = 1'b1;
    end else if (c == 8'h0D || c == 8'h0A) begin
      if (m_real > 0) begin
        v = '0;
        d = '0;
        for (int k = 0; k < 4; k++) begin
          if (m_nib.size() - 1 - k >= 0) begin
            v[4*k +: 4] = m_nib[m_nib.size()-1-k];
            d[k]        = m_dot[m_dot.size()-1-k];
          end
        end
        exp_q.push_back({v, d});
      end
      model_clear();
    end else begin
      m_cerr = 1'b1;
      model_clear();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bit seen;
    string dig_pool;
    string bad_pool;
    logic [7:0] ch;
    int r;

    bus.usb_rx  = 1'b1;
    bus.err_clr = 1'b0;

    set_vec(0, "BEEF",   8'h0D, 16'hBEEF, 4'b0000, 1, 1'b0, 1'b0);
    set_vec(1, "12.34",  8'h0A, 16'h1234, 4'b0100, 1, 1'b0, 1'b0);
    set_vec(2, "",       8'h0D, 16'h1234, 4'b0100, 0, 1'b0, 1'b0);
    set_vec(3, "123456", 8'h0D, 16'h3456, 4'b0000, 1, 1'b0, 1'b0);
    set_vec(4, "a5",     8'h0D, 16'h00A5, 4'b0000, 1, 1'b0, 1'b0);
    set_vec(5, "7",      8'h0D, 16'h0007, 4'b0000, 1, 1'b1, 1'b0);
    set_vec(6, "1x2",    8'h0D, 16'h0002, 4'b0000, 1, 1'b0, 1'b1);
    set_vec(7, "C",      8'h0D, 16'h000C, 4'b0000, 1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("rst_value", bus.disp_value, 16'h0000);
    check("rst_dots", bus.disp_dots, 4'h0);
    check("rst_update", bus.disp_update, 1'b0);
    check("rst_errs", {bus.err_frame, bus.err_char}, 2'b00);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 5; i++) apply_vec(i);

    // Short low glitch: false start, nothing reported.
    base = upd_cnt;
    @(negedge clk) bus.usb_rx = 1'b0;
    repeat (30) @(negedge clk);
    bus.usb_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_updates", upd_cnt - base, 0);
    check("glitch_errs", {bus.err_frame, bus.err_char}, 2'b00);
    check("glitch_state", bus.dbg_rx_state, RX_IDLE);

    // Stop bit held low: framing error, byte dropped.
    base = upd_cnt;
    send_frame(8'h41, 1'b0);
    repeat (5) @(negedge clk);
    check("ferr_flag", bus.err_frame, 1'b1);
    check("ferr_updates", upd_cnt - base, 0);
    check("ferr_value", bus.disp_value, 16'h00A5);

    apply_vec(5);
    pulse_clr();
    @(negedge clk);
    check("ferr_cleared", bus.err_frame, 1'b0);

    apply_vec(6);

    // err_clr held high across a bad byte: the set must win.
    pulse_clr();
    @(negedge clk);
    check("cerr_cleared", bus.err_char, 1'b0);
    seen = 1'b0;
    fork
      send_frame("z", 1'b1);
      begin
        for (int t = 0; t < 1200 && bus.dbg_rx_state != RX_STOP; t++) @(negedge clk);
        bus.err_clr = 1'b1;
        for (int t = 0; t < 300; t++) begin
          @(negedge clk);
          if (bus.err_char) begin
            seen = 1'b1;
            break;
          end
        end
        bus.err_clr = 1'b0;
      end
    join
    check("cerr_set_wins", seen, 1'b1);
    repeat (5) @(negedge clk);
    check("cerr_sticky", bus.err_char, 1'b1);

    // Reset in the middle of the data bits of 'F'.
    @(negedge clk) bus.usb_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.usb_rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_value", bus.disp_value, 16'h0000);
    check("midrst_dots", bus.disp_dots, 4'h0);
    check("midrst_update", bus.disp_update, 1'b0);
    check("midrst_errs", {bus.err_frame, bus.err_char}, 2'b00);
    check("midrst_state", bus.dbg_rx_state, RX_IDLE);
    bus.usb_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    apply_vec(7);

    // Random characters against the model.
    dig_pool = "0123456789ABCDEFabcdef";
    bad_pool = "xG :/@`g";
    pulse_clr();
    model_clear();
    m_cerr = 1'b0;
    act_q.delete();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 19);
      if (i == 23)      ch = 8'h0D;
      else if (r < 12)  ch = dig_pool[$urandom_range(0, 21)];
      else if (r < 15)  ch = ".";
      else if (r < 17)  ch = 8'h0D;
      else if (r < 18)  ch = 8'h0A;
      else              ch = bad_pool[$urandom_range(0, 7)];
      model_byte(ch);
      send_frame(ch, 1'b1);
      repeat (3) @(negedge clk);
      check($sformatf("rnd%0d_count", i), act_q.size(), exp_q.size());
      while (act_q.size() > 0 && exp_q.size() > 0)
        check($sformatf("rnd%0d_update", i), act_q.pop_front(), exp_q.pop_front());
      act_q.delete();
      exp_q.delete();
    end
    check("rnd_err_char", bus.err_char, m_cerr);
    check("rnd_err_frame", bus.err_frame, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
